// File: rtl/qspi_tx_serializer_if.sv
// FIFO read port and QSPI pad bundle for the TX serializer.
// master = serializer side, slave = FIFO/pad side.
interface qspi_tx_serializer_if #(
    parameter int DWID = 8
);
    logic            fifo_empty;
    logic [DWID-1:0] fifo_rdata;
    logic            fifo_ren;
    logic            sck;
    logic            cs_n;
    logic [3:0]      io_out;
    logic [3:0]      io_oe;

    modport master (
        input  fifo_empty, fifo_rdata,
        output fifo_ren, sck, cs_n, io_out, io_oe
    );

    modport slave (
        output fifo_empty, fifo_rdata,
        input  fifo_ren, sck, cs_n, io_out, io_oe
    );
endinterface

// File: rtl/qspi_tx_serializer.sv
// TX FIFO consumer: pops words and shifts them MSB-first
// onto 1/2/4 QSPI lanes with SCK and chip-select generation.
module qspi_tx_serializer #(
    parameter int DWID   = 8,
    parameter int DIVWID = 8,
    parameter int LENWID = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LENWID-1:0]   len,
    input  logic [1:0]          mode,
    input  logic [DIVWID-1:0]   clkdiv,
    input  logic                cpol,
    output logic                busy,
    output logic                done,
    output logic                underrun,
    qspi_tx_serializer_if.master bus
);
    localparam int BW = $clog2(DWID + 1);
    localparam logic [BW-1:0]     BITS_FULL = BW'(DWID);
    localparam logic [DIVWID-1:0] DIV_ONE   = DIVWID'(1);
    localparam logic [LENWID-1:0] LEN_ONE   = LENWID'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_FETCH,
        S_SHIFT,
        S_HOLD
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [DIVWID-1:0] div_q, div_d;
    logic [DIVWID-1:0] cnt_q, cnt_d;
    logic              cpol_q, cpol_d;
    logic [LENWID-1:0] rem_q, rem_d;
    logic [DWID-1:0]   sh_q, sh_d;
    logic [BW-1:0]     bits_q, bits_d;
    logic              sck_q, sck_d;
    logic              done_q, done_d;
    logic              unr_q, unr_d;

    logic          tick;
    logic          ren;
    logic [BW-1:0] step;
    logic [3:0]    mask;
    logic [3:0]    lane;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            cpol_q  <= 1'b0;
            rem_q   <= '0;
            sh_q    <= '0;
            bits_q  <= '0;
            sck_q   <= 1'b0;
            done_q  <= 1'b0;
            unr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            cpol_q  <= cpol_d;
            rem_q   <= rem_d;
            sh_q    <= sh_d;
            bits_q  <= bits_d;
            sck_q   <= sck_d;
            done_q  <= done_d;
            unr_q   <= unr_d;
        end
    end

    // Lane geometry; mode 11 falls back to single.
    always_comb begin
        step = BW'(1);
        mask = 4'b0001;
        lane = '0;
        unique case (1'b1)
            mode_q == 2'b01: begin
                step      = BW'(2);
                mask      = 4'b0011;
                lane[1:0] = sh_q[DWID-1 -: 2];
            end
            mode_q == 2'b10: begin
                step = BW'(4);
                mask = 4'b1111;
                lane = sh_q[DWID-1 -: 4];
            end
            default: begin
                lane[0] = sh_q[DWID-1];
            end
        endcase
    end

    assign tick = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        cpol_d  = cpol_q;
        rem_d   = rem_q;
        sh_d    = sh_q;
        bits_d  = bits_q;
        sck_d   = sck_q;
        done_d  = 1'b0;
        unr_d   = unr_q;
        ren     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    unr_d = 1'b0;
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        mode_d  = mode;
                        div_d   = clkdiv;
                        cnt_d   = clkdiv;
                        cpol_d  = cpol;
                        sck_d   = cpol;
                        rem_d   = len;
                        sh_d    = '0;
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                if (tick) state_d = S_FETCH;
                else      cnt_d   = cnt_q - DIV_ONE;
            end
            S_FETCH: begin
                if (bus.fifo_empty) begin
                    unr_d = 1'b1;
                end else begin
                    ren     = 1'b1;
                    sh_d    = bus.fifo_rdata;
                    bits_d  = BITS_FULL;
                    cnt_d   = div_q;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (!tick) begin
                    cnt_d = cnt_q - DIV_ONE;
                end else begin
                    cnt_d = div_q;
                    if (sck_q == cpol_q) begin
                        sck_d = ~cpol_q;
                    end else begin
                        // Trailing edge: advance to the next beat.
                        sck_d  = cpol_q;
                        sh_d   = sh_q << step;
                        bits_d = bits_q - step;
                        if (bits_q == step) begin
                            rem_d   = rem_q - LEN_ONE;
                            state_d = (rem_q == LEN_ONE) ? S_HOLD : S_FETCH;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (tick) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - DIV_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign underrun     = unr_q;
    assign bus.fifo_ren = ren & ~rst;
    assign bus.sck      = sck_q;
    assign bus.cs_n     = (state_q == S_IDLE);
    assign bus.io_oe    = busy ? mask : 4'b0000;
    assign bus.io_out   = (state_q == S_SHIFT) ? lane : 4'b0000;
endmodule

// File: tb/tb_qspi_tx_serializer.sv
// Self-checking bench for qspi_tx_serializer: directed table,
// hand-written corner sequences and randomized transfers.
module tb_qspi_tx_serializer;
    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        start  = 1'b0;
    logic [15:0] len    = '0;
    logic [1:0]  mode   = '0;
    logic [7:0]  clkdiv = '0;
    logic        cpol   = 1'b0;
    logic        busy;
    logic        done;
    logic        underrun;

    qspi_tx_serializer_if #(.DWID(8)) bus ();

    qspi_tx_serializer #(
        .DWID(8),
        .DIVWID(8),
        .LENWID(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .len(len),
        .mode(mode),
        .clkdiv(clkdiv),
        .cpol(cpol),
        .busy(busy),
        .done(done),
        .underrun(underrun),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [7:0] fq[$];
    logic [7:0] sent[$];
    logic [3:0] got[$];
    logic [3:0] expv[$];
    int pops    = 0;
    int ren_bad = 0;
    int passed  = 0;
    int total   = 0;

    int   cs_low, dones, oe_bad, half_bad, done_ok, npops, busy_cyc;
    logic stall_ok, unr0;

    // FIFO model: head visible after each edge, popped on fifo_ren.
    always @(posedge clk) begin
        if (bus.fifo_ren) begin
            if (bus.fifo_empty) ren_bad++;
            if (fq.size() > 0) void'(fq.pop_front());
            pops++;
        end
        bus.fifo_empty <= (fq.size() == 0);
        bus.fifo_rdata <= (fq.size() > 0) ? fq[0] : 8'h00;
    end

    typedef struct {
        logic [1:0]  m;
        logic        cp;
        logic [7:0]  dv;
        int          n;
        logic [15:0] w;
        logic [63:0] ev;
        int          ne;
        int          cs;
    } vec_t;

    vec_t tbl[3];

    function automatic void chk(input string nm, input longint a,
                                input longint e);
        total++;
        if (a == e) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, a, e);
    endfunction

    function automatic int lanes(input logic [1:0] m);
        return (m == 2'b01) ? 2 : (m == 2'b10) ? 4 : 1;
    endfunction

    task automatic push(input logic [7:0] w);
        fq.push_back(w);
        sent.push_back(w);
    endtask

    // Reference: each word split into MSB-first lane groups.
    task automatic model(input logic [1:0] m);
        int lw;
        int v;
        lw = lanes(m);
        expv.delete();
        foreach (sent[w]) begin
            v = int'(sent[w]);
            for (int b = 0; b < 8 / lw; b++)
                expv.push_back(4'((v >> (8 - lw * (b + 1))) & ((1 << lw) - 1)));
        end
    endtask

    task automatic chk_edges(input string tag);
        chk({tag, "_nedges"}, got.size(), expv.size());
        for (int i = 0; i < expv.size() && i < got.size(); i++)
            chk($sformatf("%s_edge%0d", tag, i), got[i], expv[i]);
    endtask

    task automatic xfer(input logic [1:0] m, input logic cp,
                        input logic [7:0] dv, input int n,
                        input int late, input logic [7:0] late_w,
                        input int restart);
        int   p0;
        int   run;
        int   tail;
        int   since;
        logic prev_sck;
        logic prev_cs;
        p0 = pops;
        run = 0;
        tail = -1;
        since = 0;
        prev_sck = cp;
        prev_cs = 1'b1;
        got.delete();
        cs_low = 0; dones = 0; oe_bad = 0; half_bad = 0;
        done_ok = 0; busy_cyc = 0; stall_ok = 1'b0;
        @(negedge clk);
        start = 1'b1; len = 16'(n); mode = m; clkdiv = dv; cpol = cp;
        @(negedge clk);
        start  = 1'b0;
        len    = 16'($urandom_range(1, 9));
        mode   = 2'($urandom);
        clkdiv = 8'($urandom);
        cpol   = 1'($urandom);
        unr0   = underrun;
        for (int cyc = 0; cyc < 4000 && tail != 0; cyc++) begin
            if (busy) busy_cyc++;
            if (!bus.cs_n) begin
                cs_low++;
                if (bus.io_oe != 4'((1 << lanes(m)) - 1)) oe_bad++;
            end
            if (bus.sck != prev_sck && bus.sck != cp)
                got.push_back(bus.io_out);
            if (bus.sck != cp) begin
                run++;
            end else if (run != 0) begin
                if (run != int'(dv) + 1) half_bad++;
                run = 0;
            end
            if (done) begin
                dones++;
                if (bus.cs_n && !prev_cs) done_ok++;
                if (tail < 0) tail = 4;
            end
            if (late > 0 && pops - p0 == 1) begin
                since++;
                if (since == late) begin
                    stall_ok = !bus.cs_n && bus.sck == cp && underrun && busy;
                    fq.push_back(late_w);
                    sent.push_back(late_w);
                end
            end
            start = (cyc == restart);
            if (start) len = 16'd3;
            prev_sck = bus.sck;
            prev_cs  = bus.cs_n;
            if (tail > 0) tail--;
            @(negedge clk);
        end
        start = 1'b0;
        npops = pops - p0;
    endtask

    task automatic chk_common(input string tag, input int n,
                              input logic cp);
        chk({tag, "_pops"}, npops, n);
        chk({tag, "_dones"}, dones, 1);
        chk({tag, "_done_at_cs_rise"}, done_ok, 1);
        chk({tag, "_oe_bad"}, oe_bad, 0);
        chk({tag, "_half_bad"}, half_bad, 0);
        chk({tag, "_sck_idle"}, bus.sck, cp);
    endtask

    initial begin
        logic [1:0] m;
        logic       cp;
        logic [7:0] dv;
        int         n;
        int         p0;

        tbl[0] = '{2'b00, 1'b0, 8'd0, 1, 16'hA500, 64'h1010_0101, 8, 19};
        tbl[1] = '{2'b10, 1'b0, 8'd1, 2, 16'h3CF0, 64'h0FC3, 4, 22};
        tbl[2] = '{2'b01, 1'b1, 8'd0, 1, 16'h1B00, 64'h3210, 4, 11};

        repeat (3) @(negedge clk);
        chk("rst_cs_n", bus.cs_n, 1);
        chk("rst_sck", bus.sck, 0);
        chk("rst_io_oe", bus.io_oe, 0);
        chk("rst_io_out", bus.io_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_ren", bus.fifo_ren, 0);
        rst = 1'b0;

        for (int t = 0; t < 3; t++) begin
            sent.delete();
            push(tbl[t].w[15:8]);
            if (tbl[t].n == 2) push(tbl[t].w[7:0]);
            xfer(tbl[t].m, tbl[t].cp, tbl[t].dv, tbl[t].n, 0, 8'h00, -1);
            expv.delete();
            for (int i = 0; i < tbl[t].ne; i++)
                expv.push_back(tbl[t].ev[4 * i +: 4]);
            chk_edges($sformatf("tbl%0d", t));
            chk($sformatf("tbl%0d_cs_low", t), cs_low, tbl[t].cs);
            chk_common($sformatf("tbl%0d", t), tbl[t].n, tbl[t].cp);
            chk($sformatf("tbl%0d_underrun", t), underrun, 0);
        end

        sent.delete();
        xfer(2'b00, 1'b0, 8'd0, 0, 0, 8'h00, -1);
        chk("len0_dones", dones, 1);
        chk("len0_cs_low", cs_low, 0);
        chk("len0_pops", npops, 0);
        chk("len0_busy", busy_cyc, 0);

        sent.delete();
        push(8'h96);
        fq.push_back(8'h69);
        xfer(2'b00, 1'b0, 8'd0, 1, 0, 8'h00, 5);
        model(2'b00);
        chk_edges("busy_start");
        chk_common("busy_start", 1, 1'b0);
        chk("busy_start_fifo_left", fq.size(), 1);
        fq.delete();
        repeat (2) @(negedge clk);

        sent.delete();
        push(8'h81);
        xfer(2'b00, 1'b0, 8'd0, 2, 26, 8'h7E, -1);
        model(2'b00);
        chk_edges("unr");
        chk_common("unr", 2, 1'b0);
        chk("unr_stall_state", stall_ok, 1);
        chk("unr_sticky", underrun, 1);

        sent.delete();
        push(8'hC3);
        xfer(2'b10, 1'b0, 8'd0, 1, 0, 8'h00, -1);
        model(2'b10);
        chk_edges("unr_clr");
        chk("unr_clr_at_start", unr0, 0);
        chk("unr_clr_end", underrun, 0);

        for (int r = 0; r < 20; r++) begin
            m  = 2'($urandom_range(0, 3));
            cp = 1'($urandom_range(0, 1));
            dv = 8'($urandom_range(0, 3));
            n  = $urandom_range(1, 4);
            sent.delete();
            for (int k = 0; k < n; k++) push(8'($urandom));
            xfer(m, cp, dv, n, 0, 8'h00, -1);
            model(m);
            chk_edges($sformatf("rnd%0d", r));
            chk($sformatf("rnd%0d_cs_low", r), cs_low,
                (int'(dv) + 1) * (2 + 2 * (8 / lanes(m)) * n) + n);
            chk_common($sformatf("rnd%0d", r), n, cp);
        end

        sent.delete();
        push(8'h3C);
        push(8'hF0);
        p0 = pops;
        @(negedge clk);
        start = 1'b1; len = 16'd2; mode = 2'b10; clkdiv = 8'd1; cpol = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && pops == p0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("rstmid_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_cs_n", bus.cs_n, 1);
        chk("rstmid_io_oe", bus.io_oe, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_sck", bus.sck, 0);
        chk("rstmid_ren", bus.fifo_ren, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("rstmid_pops", pops - p0, 1);
        chk("rstmid_cs_stays", bus.cs_n, 1);
        fq.delete();

        chk("ren_while_empty", ren_bad, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
